branch_pc_unit: RTL and testbench

Program-counter and branch-target stage of the multicycle MIPS datapath. It consumes the ALU result: PC+4 during fetch, or PC+4 plus the shifted, sign-extended offset during decode. It latches the branch target, forms jump targets from the 26-bit instruction index, resolves beq/bne, and holds the architectural PC. It replaces the ad-hoc PC register and PCSource mux, and sits directly downstream of the immediate shift-left-2 path and the ALU.

---
 rtl/mips_pkg.sv | 11 +
 rtl/jump_target_former.sv | 11 +
 rtl/branch_pc_unit.sv | 91 +++++++++
 tb/tb_branch_pc_unit.sv | 134 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: PC source select encodings and reset vector.
package mips_pkg;

  localparam logic [1:0] PC_SRC_ALU  = 2'b00;
  localparam logic [1:0] PC_SRC_TGT  = 2'b01;
  localparam logic [1:0] PC_SRC_JMP  = 2'b10;
  localparam logic [1:0] PC_SRC_HOLD = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/jump_target_former.sv
// J-type target formation: region bits of the current PC plus the word index.
module jump_target_former (
  input  logic [3:0]  pc_hi,
  input  logic [25:0] instr_index,
  output logic [31:0] jump_target
);

  // The index is shifted into a word address; it can never carry into the region bits.
  assign jump_target = {pc_hi, instr_index, 2'b00};

endmodule

// File: rtl/branch_pc_unit.sv
// Architectural PC, latched branch target, beq/bne resolution and taken-branch counter
// for the multicycle MIPS datapath.
module branch_pc_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      alu_result,
  input  logic             zero,
  input  logic [25:0]      instr_index,
  input  logic             target_load,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic             branch_ne,
  input  logic [1:0]       pc_source,
  output logic [31:0]      pc,
  output logic [31:0]      target,
  output logic             branch_taken,
  output logic             misaligned,
  output logic [CNT_W-1:0] taken_count
);

  logic [31:0]      r_pc;
  logic [31:0]      r_target;
  logic             r_branch_taken;
  logic             r_misaligned;
  logic [CNT_W-1:0] r_taken_count;

  logic [31:0] w_jump_target;
  logic [31:0] w_next_pc;
  logic        w_cond_ok;
  logic        w_pc_en;
  logic        w_try_update;
  logic        w_bad_align;
  logic        w_do_update;
  logic        w_taken;

  jump_target_former u_jump_target_former (
    .pc_hi       (r_pc[31:28]),
    .instr_index (instr_index),
    .jump_target (w_jump_target)
  );

  always_comb begin
    w_next_pc = r_pc;
    case (pc_source)
      PC_SRC_ALU:  w_next_pc = alu_result;
      PC_SRC_TGT:  w_next_pc = r_target;
      PC_SRC_JMP:  w_next_pc = w_jump_target;
      default:     w_next_pc = r_pc;
    endcase
  end

  assign w_cond_ok    = zero ^ branch_ne;
  assign w_pc_en      = pc_write | (pc_write_cond & w_cond_ok);
  // Hold is a true no-op: it neither updates the PC nor trips the alignment check.
  assign w_try_update = w_pc_en & (pc_source != PC_SRC_HOLD);
  assign w_bad_align  = w_try_update & (w_next_pc[1:0] != 2'b00);
  assign w_do_update  = w_try_update & ~w_bad_align;
  assign w_taken      = w_do_update & pc_write_cond & ~pc_write & w_cond_ok;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc           <= RESET_PC;
      r_target       <= 32'h0000_0000;
      r_branch_taken <= 1'b0;
      r_misaligned   <= 1'b0;
      r_taken_count  <= '0;
    end else begin
      if (w_do_update)
        r_pc <= w_next_pc;
      if (target_load)
        r_target <= alu_result;
      if (w_bad_align)
        r_misaligned <= 1'b1;
      r_branch_taken <= w_taken;
      if (w_taken && (r_taken_count != {CNT_W{1'b1}}))
        r_taken_count <= r_taken_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign pc           = r_pc;
  assign target       = r_target;
  assign branch_taken = r_branch_taken;
  assign misaligned   = r_misaligned;
  assign taken_count  = r_taken_count;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed scoreboard bench for branch_pc_unit: stimulus pushes expected state,
// a negedge monitor pops and compares it against the registered outputs.
module tb_branch_pc_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [31:0]      alu_result = '0;
  logic             zero = 1'b0;
  logic [25:0]      instr_index = '0;
  logic             target_load = 1'b0;
  logic             pc_write = 1'b0;
  logic             pc_write_cond = 1'b0;
  logic             branch_ne = 1'b0;
  logic [1:0]       pc_source = 2'b11;
  logic [31:0]      pc;
  logic [31:0]      target;
  logic             branch_taken;
  logic             misaligned;
  logic [CNT_W-1:0] taken_count;

  typedef struct {
    string      tag;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic        bt;
    logic        mis;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  branch_pc_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .alu_result    (alu_result),
    .zero          (zero),
    .instr_index   (instr_index),
    .target_load   (target_load),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_ne     (branch_ne),
    .pc_source     (pc_source),
    .pc            (pc),
    .target        (target),
    .branch_taken  (branch_taken),
    .misaligned    (misaligned),
    .taken_count   (taken_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".pc"},           pc,                    e.pc);
      chk({e.tag, ".target"},       target,                e.tgt);
      chk({e.tag, ".branch_taken"}, {31'b0, branch_taken}, {31'b0, e.bt});
      chk({e.tag, ".misaligned"},   {31'b0, misaligned},   {31'b0, e.mis});
      chk({e.tag, ".taken_count"},  {28'b0, taken_count},  {28'b0, e.cnt});
    end
  end

  // Apply one cycle of inputs; the expected state is what the outputs show after the edge.
  task automatic step(input string tag, input logic rst, input logic [31:0] alu,
                      input logic z, input logic [25:0] idx, input logic tl,
                      input logic pw, input logic pwc, input logic bne,
                      input logic [1:0] src, input logic [31:0] e_pc,
                      input logic [31:0] e_tgt, input logic e_bt, input logic e_mis,
                      input logic [3:0] e_cnt);
    exp_t e;
    reset = rst; alu_result = alu; zero = z; instr_index = idx; target_load = tl;
    pc_write = pw; pc_write_cond = pwc; branch_ne = bne; pc_source = src;
    @(posedge clk);
    e.tag = tag; e.pc = e_pc; e.tgt = e_tgt; e.bt = e_bt; e.mis = e_mis; e.cnt = e_cnt;
    exp_q.push_back(e);
    #1;
  endtask

  initial begin
    @(posedge clk); #1;
    //     tag         rst alu            z  idx          tl pw pwc bne src    pc             tgt            bt mis cnt
    step("reset",     1, 32'h0,        0, 26'h0,       0, 0, 0,  0,  2'b11, 32'h0,         32'h0,         0, 0, 4'd0);
    step("fetch",     0, 32'h4,        0, 26'h0,       0, 1, 0,  0,  2'b00, 32'h4,         32'h0,         0, 0, 4'd0);
    step("decode",    0, 32'h40,       0, 26'h0,       1, 0, 0,  0,  2'b00, 32'h4,         32'h40,        0, 0, 4'd0);
    step("beq_taken", 0, 32'h0,        1, 26'h0,       0, 0, 1,  0,  2'b01, 32'h40,        32'h40,        1, 0, 4'd1);
    step("idle0",     0, 32'h0,        0, 26'h0,       0, 0, 0,  0,  2'b11, 32'h40,        32'h40,        0, 0, 4'd1);
    step("bne_nt",    0, 32'h0,        1, 26'h0,       0, 0, 1,  1,  2'b01, 32'h40,        32'h40,        0, 0, 4'd1);
    step("set_pc",    0, 32'hA000_0010,0, 26'h0,       0, 1, 0,  0,  2'b00, 32'hA000_0010, 32'h40,        0, 0, 4'd1);
    step("jump",      0, 32'h0,        0, 26'h100,     0, 1, 0,  0,  2'b10, 32'hA000_0400, 32'h40,        0, 0, 4'd1);
    step("jump_wrap", 0, 32'h0,        0, 26'h3FF_FFFF,0, 1, 0,  0,  2'b10, 32'hAFFF_FFFC, 32'h40,        0, 0, 4'd1);
    step("misalign",  0, 32'h6,        0, 26'h0,       0, 1, 0,  0,  2'b00, 32'hAFFF_FFFC, 32'h40,        0, 1, 4'd1);
    step("after_mis", 0, 32'h8,        0, 26'h0,       0, 1, 0,  0,  2'b00, 32'h8,         32'h40,        0, 1, 4'd1);
    step("ld_badtgt", 0, 32'h13,       0, 26'h0,       1, 0, 0,  0,  2'b00, 32'h8,         32'h13,        0, 1, 4'd1);
    step("br_badtgt", 0, 32'h0,        1, 26'h0,       0, 0, 1,  0,  2'b01, 32'h8,         32'h13,        0, 1, 4'd1);
    step("hold",      0, 32'h7,        0, 26'h0,       0, 1, 0,  0,  2'b11, 32'h8,         32'h13,        0, 1, 4'd1);
    step("pw_and_pwc",0, 32'h20,       1, 26'h0,       0, 1, 1,  0,  2'b00, 32'h20,        32'h13,        0, 1, 4'd1);
    step("reset2",    1, 32'h44,       1, 26'h0,       1, 1, 1,  0,  2'b00, 32'h0,         32'h0,         0, 0, 4'd0);
    step("tgt_after", 0, 32'h0,        0, 26'h0,       0, 1, 0,  0,  2'b01, 32'h0,         32'h0,         0, 0, 4'd0);
    step("ld_100",    0, 32'h100,      0, 26'h0,       1, 0, 0,  0,  2'b00, 32'h0,         32'h100,       0, 0, 4'd0);
    for (int i = 0; i < 17; i++) begin
      logic [3:0] c;
      c = (i >= 14) ? 4'hF : 4'(i + 1);
      step($sformatf("sat%0d", i), 0, 32'h0, 1, 26'h0, 0, 0, 1, 0, 2'b01,
           32'h100, 32'h100, 1, 0, c);
    end
    step("overlap",   0, 32'h200,      0, 26'h0,       1, 1, 0,  0,  2'b01, 32'h100,       32'h200,       0, 0, 4'hF);
    step("new_tgt",   0, 32'h0,        0, 26'h0,       0, 1, 0,  0,  2'b01, 32'h200,       32'h200,       0, 0, 4'hF);
    step("bne_taken", 0, 32'h300,      0, 26'h0,       0, 0, 1,  1,  2'b00, 32'h300,       32'h200,       1, 0, 4'hF);
    step("idle1",     0, 32'h0,        0, 26'h0,       0, 0, 0,  0,  2'b11, 32'h300,       32'h200,       0, 0, 4'hF);

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
